data_mem_mmio: RTL and testbench



---
 rtl/data_mem_mmio_pkg.sv | 16 +
 rtl/data_mem_mmio_sync_fifo.sv | 53 +++++
 rtl/data_mem_mmio.sv | 115 +++++++++++
 tb/tb_data_mem_mmio.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data-side memory/MMIO responder.
// MMIO register offsets from MMIO_BASE and STAT bit positions.
package data_mem_mmio_pkg;

  localparam int OFS_OUT  = 0;
  localparam int OFS_IN   = 1;
  localparam int OFS_TXD  = 2;
  localparam int OFS_STAT = 3;
  localparam int OFS_CLR  = 4;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/data_mem_mmio_sync_fifo.sv
// Single-clock circular FIFO, first-word fall-through head.
// Ports: i_push/i_wdata in, i_pop in, o_rdata head, o_full/o_empty/o_count status.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [W-1:0]  r_buf [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = r_count[AW];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_buf[r_rd_ptr];
  // Full state uses pre-edge status, so a push on full drops even with a pop.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_buf[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-memory responder: RAM below MMIO_BASE, GPIO/TX-FIFO registers above.
// Ports: mem_addr/mem_wdata/mem_we/mem_rdata core bus, gpio_out/gpio_in, tx stream.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8,
  parameter logic [MEM_ADDR_WIDTH-1:0] MMIO_BASE = 'hF0,
  parameter int FIFO_AW = 2
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic                      mem_we,
  output logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  output logic [MEM_DATA_WIDTH-1:0] gpio_out,
  input  logic [MEM_DATA_WIDTH-1:0] gpio_in,
  output logic [MEM_DATA_WIDTH-1:0] tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int RAM_DEPTH = int'(MMIO_BASE);
  localparam int AW = MEM_ADDR_WIDTH;

  logic [MEM_DATA_WIDTH-1:0] r_ram [RAM_DEPTH];
  logic [MEM_DATA_WIDTH-1:0] r_gpio_out;
  logic [MEM_DATA_WIDTH-1:0] r_sync1;
  logic [MEM_DATA_WIDTH-1:0] r_sync2;
  logic                      r_ovf;

  logic [AW-1:0]    w_ofs;
  logic             w_sel_ram;
  logic             w_sel_out;
  logic             w_sel_in;
  logic             w_sel_stat;
  logic             w_sel_txd;
  logic             w_sel_clr;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [FIFO_AW:0] w_count;
  logic [7:0]       w_stat;
  logic [MEM_DATA_WIDTH-1:0] w_rdata;

  assign w_ofs      = mem_addr - MMIO_BASE;
  assign w_sel_ram  = (mem_addr < MMIO_BASE);
  assign w_sel_out  = !w_sel_ram && (w_ofs == AW'(OFS_OUT));
  assign w_sel_in   = !w_sel_ram && (w_ofs == AW'(OFS_IN));
  assign w_sel_txd  = !w_sel_ram && (w_ofs == AW'(OFS_TXD));
  assign w_sel_stat = !w_sel_ram && (w_ofs == AW'(OFS_STAT));
  assign w_sel_clr  = !w_sel_ram && (w_ofs == AW'(OFS_CLR));
  assign w_push     = mem_we && w_sel_txd;

  sync_fifo #(
    .W  (MEM_DATA_WIDTH),
    .AW (FIFO_AW)
  ) u_tx_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_push  (w_push),
    .i_wdata (mem_wdata),
    .i_pop   (tx_ready),
    .o_rdata (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign tx_valid = !w_empty;
  assign gpio_out = r_gpio_out;

  always_ff @(posedge clk) begin
    if (mem_we && w_sel_ram) r_ram[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (mem_we && w_sel_out) r_gpio_out <= mem_wdata;
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (mem_we && w_sel_clr && mem_wdata[2]) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_stat = '0;
    w_stat[STAT_EMPTY] = w_empty;
    w_stat[STAT_FULL]  = w_full;
    w_stat[STAT_OVF]   = r_ovf;
    w_stat[STAT_CNT_LSB +: 4] = 4'(w_count);
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_ram:  w_rdata = r_ram[mem_addr];
      w_sel_out:  w_rdata = r_gpio_out;
      w_sel_in:   w_rdata = r_sync2;
      w_sel_stat: w_rdata = MEM_DATA_WIDTH'(w_stat);
      default:    w_rdata = '0;
    endcase
  end

  assign mem_rdata = w_rdata;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: RAM, GPIO, TX FIFO, overflow and reset.
// TX words are queued on push and compared as the stream hands them off.
module tb_data_mem_mmio;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic       mem_we = 1'b0;
  logic [7:0] mem_rdata;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q_tx[$];

  always #5 clk = ~clk;

  data_mem_mmio dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    mem_addr = a;
    #1;
    d = mem_rdata;
  endtask

  task automatic push(input logic [7:0] d);
    q_tx.push_back(d);
    wr(8'hF2, d);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    #3;
    n_vec++;
    if (tx_valid !== 1'b0 || gpio_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_out: tx_valid=%b gpio_out=%h want 0/00", tx_valid, gpio_out);
    end
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h01) begin
      n_err++;
      $display("FAIL reset_stat: got %h want 01", d);
    end
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ram;
    logic [7:0] d;
    wr(8'h10, 8'h5A);
    rd(8'h10, d);
    n_vec++;
    if (d !== 8'h5A) begin
      n_err++;
      $display("FAIL ram_10: got %h want 5A", d);
    end
    wr(8'hEF, 8'hC3);
    rd(8'hEF, d);
    n_vec++;
    if (d !== 8'hC3) begin
      n_err++;
      $display("FAIL ram_EF: got %h want C3", d);
    end
    rd(8'hF5, d);
    n_vec++;
    if (d !== 8'h00) begin
      n_err++;
      $display("FAIL rd_unmapped: got %h want 00", d);
    end
  endtask

  task automatic test_gpio;
    logic [7:0] d;
    wr(8'hF0, 8'h81);
    n_vec++;
    if (gpio_out !== 8'h81) begin
      n_err++;
      $display("FAIL gpio_out: got %h want 81", gpio_out);
    end
    rd(8'hF0, d);
    n_vec++;
    if (d !== 8'h81) begin
      n_err++;
      $display("FAIL rd_out: got %h want 81", d);
    end
    gpio_in = 8'h3C;
    rd(8'hF1, d);
    n_vec++;
    if (d !== 8'h00) begin
      n_err++;
      $display("FAIL gpio_in_e0: got %h want 00", d);
    end
    @(posedge clk);
    #1;
    rd(8'hF1, d);
    n_vec++;
    if (d !== 8'h00) begin
      n_err++;
      $display("FAIL gpio_in_e1: got %h want 00", d);
    end
    @(posedge clk);
    #1;
    rd(8'hF1, d);
    n_vec++;
    if (d !== 8'h3C) begin
      n_err++;
      $display("FAIL gpio_in_e2: got %h want 3C", d);
    end
    wr(8'hF1, 8'hFF);
    rd(8'hF1, d);
    n_vec++;
    if (d !== 8'h3C || gpio_out !== 8'h81) begin
      n_err++;
      $display("FAIL in_wr_ign: in=%h out=%h want 3C/81", d, gpio_out);
    end
  endtask

  task automatic test_fill;
    logic [7:0] d;
    tx_ready = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h42) begin
      n_err++;
      $display("FAIL stat_full: got %h want 42", d);
    end
    wr(8'hF2, 8'h55);
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h46) begin
      n_err++;
      $display("FAIL stat_ovf: got %h want 46", d);
    end
    rd(8'hF2, d);
    n_vec++;
    if (d !== 8'h00) begin
      n_err++;
      $display("FAIL rd_txd: got %h want 00", d);
    end
    wr(8'hF4, 8'hFB);
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h46) begin
      n_err++;
      $display("FAIL clr_nobit: got %h want 46", d);
    end
    wr(8'hF4, 8'h04);
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h42) begin
      n_err++;
      $display("FAIL clr_ovf: got %h want 42", d);
    end
  endtask

  task automatic drain;
    int cyc = 0;
    tx_ready = 1'b1;
    while (q_tx.size() > 0 && cyc < 20) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== q_tx[0]) begin
        n_err++;
        $display("FAIL tx_word: valid=%b data=%h want 1/%h", tx_valid, tx_data, q_tx[0]);
      end
      void'(q_tx.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    tx_ready = 1'b0;
    n_vec++;
    if (q_tx.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: left=%0d want 0", q_tx.size());
    end
  endtask

  task automatic test_drain;
    logic [7:0] d;
    drain();
    rd(8'hF3, d);
    n_vec++;
    if (tx_valid !== 1'b0 || d !== 8'h01) begin
      n_err++;
      $display("FAIL drained: valid=%b stat=%h want 0/01", tx_valid, d);
    end
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h42) begin
      n_err++;
      $display("FAIL refill: got %h want 42", d);
    end
    drain();
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h01) begin
      n_err++;
      $display("FAIL redrain: got %h want 01", d);
    end
  endtask

  task automatic test_push_pop;
    logic [7:0] d;
    push(8'h77);
    tx_ready = 1'b1;
    n_vec++;
    if (tx_data !== q_tx[0]) begin
      n_err++;
      $display("FAIL pp_head: got %h want %h", tx_data, q_tx[0]);
    end
    void'(q_tx.pop_front());
    push(8'h99);
    tx_ready = 1'b0;
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h10 || tx_data !== q_tx[0]) begin
      n_err++;
      $display("FAIL pp_cnt1: stat=%h data=%h want 10/%h", d, tx_data, q_tx[0]);
    end
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    tx_ready = 1'b1;
    n_vec++;
    if (tx_data !== q_tx[0]) begin
      n_err++;
      $display("FAIL fp_head: got %h want %h", tx_data, q_tx[0]);
    end
    void'(q_tx.pop_front());
    wr(8'hF2, 8'hDD);
    tx_ready = 1'b0;
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h34 || tx_data !== q_tx[0]) begin
      n_err++;
      $display("FAIL full_pop: stat=%h data=%h want 34/%h", d, tx_data, q_tx[0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    arst_n = 1'b0;
    q_tx.delete();
    #2;
    n_vec++;
    if (tx_valid !== 1'b0 || gpio_out !== 8'h00) begin
      n_err++;
      $display("FAIL async_rst: valid=%b out=%h want 0/00", tx_valid, gpio_out);
    end
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(8'hF3, d);
    n_vec++;
    if (d !== 8'h01) begin
      n_err++;
      $display("FAIL rst_stat: got %h want 01", d);
    end
    rd(8'h10, d);
    n_vec++;
    if (d !== 8'h5A) begin
      n_err++;
      $display("FAIL ram_keep10: got %h want 5A", d);
    end
    rd(8'hEF, d);
    n_vec++;
    if (d !== 8'hC3) begin
      n_err++;
      $display("FAIL ram_keepEF: got %h want C3", d);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_fill();
    test_drain();
    test_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
